// File: rtl/fifo_defs.sv
// Shared definitions for the fifo serializer: state encoding and
// parameter helpers used at elaboration time.
package fifo_defs;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    function automatic int calc_cw(input int in_w, input int out_w);
        int ratio;
        ratio = in_w / out_w;
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic bit cfg_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

endpackage

// File: rtl/fifo_serializer.sv
// Drains wide words from a show-ahead fifo and emits narrow beats
// over a valid/ready handshake, refilling without bubbles.
module fifo_serializer
    import fifo_defs::*;
#(
    parameter int IN_W      = 256,
    parameter int OUT_W     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [IN_W-1:0]  fifo_rd_data,
    output logic             fifo_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             flush,
    output logic             busy
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CW    = calc_cw(IN_W, OUT_W);
    localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

    generate
        if (!cfg_ok(IN_W, OUT_W)) begin : g_bad_cfg
            $error("fifo_serializer: IN_W must be a multiple of OUT_W, ratio >= 2");
        end
    endgenerate

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   bcnt;
    logic [IN_W-1:0] shreg;
    logic [IN_W-1:0] shifted;
    logic            xfer;
    logic            at_last;

    assign xfer    = (state == ST_BUSY) && out_ready;
    assign at_last = (state == ST_BUSY) && (bcnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: if (fifo_rd) nxt = ST_BUSY;
                ST_BUSY:  if (xfer && at_last && !fifo_rd) nxt = ST_EMPTY;
            endcase
        end
    end

    // Refill happens either from idle or on the final beat's transfer.
    always_comb begin
        out_valid = (state == ST_BUSY);
        out_last  = at_last;
        fifo_rd   = 1'b0;
        if (rst && !fifo_empty && !flush) begin
            fifo_rd = (state == ST_EMPTY) || (xfer && at_last);
        end
    end

    assign busy = out_valid;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign shifted  = shreg >> OUT_W;
            assign out_data = shreg[OUT_W-1:0];
        end else begin : g_msb
            assign shifted  = shreg << OUT_W;
            assign out_data = shreg[IN_W-1 -: OUT_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (flush) begin
            bcnt  <= '0;
        end else if (fifo_rd) begin
            shreg <= fifo_rd_data;
            bcnt  <= '0;
        end else if (xfer && !at_last) begin
            shreg <= shifted;
            bcnt  <= bcnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: LSB-first and MSB-first instances fed by
// queue-based show-ahead fifos, checked against a beat-list model.
module tb_fifo_serializer;

    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        flush;
    logic        push_en;
    logic [31:0] push_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic       o_valid [2];
    logic       o_last  [2];
    logic       o_rd    [2];
    logic [7:0] o_data  [2];
    int         fcnt    [2];
    int         rd_cnt  [2];

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h",
                     name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit LSB = (g == 0);

        logic        f_empty = 1'b1;
        logic [31:0] f_head  = '0;
        logic [31:0] fq[$];
        int          n_words = 0;
        int          rc      = 0;
        logic        rd;
        logic        valid;
        logic        last;
        logic        bsy;
        logic [7:0]  data;

        logic [7:0]  cur[$];
        bit          m_flush = 0;
        bit          m_xfer  = 0;
        bit          m_rd    = 0;
        logic [31:0] m_head  = '0;

        fifo_serializer #(
            .IN_W(32), .OUT_W(8), .LSB_FIRST(LSB)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .fifo_empty(f_empty),
            .fifo_rd_data(f_head),
            .fifo_rd(rd),
            .out_valid(valid),
            .out_ready(out_ready),
            .out_data(data),
            .out_last(last),
            .flush(flush),
            .busy(bsy)
        );

        assign o_valid[g] = valid;
        assign o_last[g]  = last;
        assign o_rd[g]    = rd;
        assign o_data[g]  = data;
        assign fcnt[g]    = n_words;
        assign rd_cnt[g]  = rc;

        function automatic logic [7:0] beat(input logic [31:0] w, input int i);
            int pos;
            pos = LSB ? i : (RATIO - 1 - i);
            return 8'((w >> (pos * 8)) & 32'hFF);
        endfunction

        // Show-ahead fifo: head/empty update after the edge like a register.
        always @(posedge clk) begin
            if (rd) begin
                check("no_underflow", g, 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) void'(fq.pop_front());
            end
            if (push_en) fq.push_back(push_data);
            n_words <= fq.size();
            f_empty <= (fq.size() == 0);
            f_head  <= (fq.size() != 0) ? fq[0] : 32'h0;
        end

        always @(negedge clk) begin : cmp
            bit v_e;
            bit rd_e;
            v_e  = rst && (cur.size() != 0);
            rd_e = rst && !f_empty && !flush &&
                   ((cur.size() == 0) || (out_ready && cur.size() == 1));
            check("valid", g, 32'(valid), 32'(v_e));
            check("busy", g, 32'(bsy), 32'(v_e));
            check("fifo_rd", g, 32'(rd), 32'(rd_e));
            if (v_e) begin
                check("data", g, 32'(data), 32'(cur[0]));
                check("last", g, 32'(last), 32'(cur.size() == 1));
            end else begin
                check("last_idle", g, 32'(last), 32'd0);
            end
            if (rd) rc++;
            m_flush = flush;
            m_xfer  = v_e && out_ready;
            m_rd    = rd_e;
            m_head  = f_head;
        end

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                cur.delete();
            end else if (m_flush) begin
                cur.delete();
            end else if (m_rd) begin
                cur.delete();
                for (int i = 0; i < RATIO; i++) cur.push_back(beat(m_head, i));
            end else if (m_xfer) begin
                void'(cur.pop_front());
            end
        end
    end

    task automatic push(input logic [31:0] w);
        push_en   = 1'b1;
        push_data = w;
        @(posedge clk);
        #1;
        push_en = 1'b0;
    endtask

    task automatic see(input int inst, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input logic rd_last);
        logic [7:0] exp [4];
        exp[0] = b0;
        exp[1] = b1;
        exp[2] = b2;
        exp[3] = b3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lit_valid", inst, 32'(o_valid[inst]), 32'd1);
            check("lit_data", inst, 32'(o_data[inst]), 32'(exp[i]));
            check("lit_last", inst, 32'(o_last[inst]), 32'(i == 3));
            if (i == 3) check("lit_rd_last", inst, 32'(o_rd[inst]), 32'(rd_last));
        end
    endtask

    initial begin
        int         r0;
        logic [7:0] got[$];
        bit         pat [7];

        rst       = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        push_en   = 1'b0;
        push_data = '0;
        pat       = '{1, 0, 0, 1, 1, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 0, 32'(o_valid[0]), 32'd0);
        check("rst_last", 0, 32'(o_last[0]), 32'd0);
        check("rst_rd", 0, 32'(o_rd[0]), 32'd0);
        rst = 1'b1;

        // single word, one-cycle latency, both beat orders
        @(posedge clk);
        #1;
        r0 = rd_cnt[0];
        push(32'hDDCCBBAA);
        @(negedge clk);
        check("lat_valid", 0, 32'(o_valid[0]), 32'd0);
        check("lat_rd", 0, 32'(o_rd[0]), 32'd1);
        fork
            see(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
            see(1, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 1'b0);
        join
        @(negedge clk);
        check("drain_valid", 0, 32'(o_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("one_rd", 0, 32'(rd_cnt[0] - r0), 32'd1);

        // back-to-back words with no bubble
        push(32'h04030201);
        push(32'h08070605);
        fork
            begin
                see(0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
                see(0, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
            end
            begin
                see(1, 8'h04, 8'h03, 8'h02, 8'h01, 1'b1);
                see(1, 8'h08, 8'h07, 8'h06, 8'h05, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // backpressure
        r0 = rd_cnt[0];
        push(32'hDDCCBBAA);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            if (o_valid[0] && out_ready) got.push_back(o_data[0]);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check("bp_count", 0, 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("bp_b0", 0, 32'(got[0]), 32'hAA);
            check("bp_b1", 0, 32'(got[1]), 32'hBB);
            check("bp_b2", 0, 32'(got[2]), 32'hCC);
            check("bp_b3", 0, 32'(got[3]), 32'hDD);
        end
        check("bp_idle", 0, 32'(o_valid[0]), 32'd0);
        check("bp_one_rd", 0, 32'(rd_cnt[0] - r0), 32'd1);

        // restart after underflow guard
        repeat (3) @(posedge clk);
        #1;
        push(32'h0D0C0B0A);
        @(negedge clk);
        check("restart_rd", 0, 32'(o_rd[0]), 32'd1);
        see(0, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // flush mid-word with next word queued
        push(32'hDDCCBBAA);
        push(32'h44332211);
        @(negedge clk);
        check("fl_aa", 0, 32'(o_data[0]), 32'hAA);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fl_bb", 0, 32'(o_data[0]), 32'hBB);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("fl_no_rd", 0, 32'(o_rd[0]), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_empty", 0, 32'(o_valid[0]), 32'd0);
        check("fl_refill", 0, 32'(o_rd[0]), 32'd1);
        fork
            see(0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
            see(1, 8'h44, 8'h33, 8'h22, 8'h11, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset mid-word
        push(32'hDDCCBBAA);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ar_valid0", 0, 32'(o_valid[0]), 32'd0);
        check("ar_valid1", 1, 32'(o_valid[1]), 32'd0);
        check("ar_rd0", 0, 32'(o_rd[0]), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(32'hDDCCBBAA);
        @(negedge clk);
        check("ar_lat_rd", 0, 32'(o_rd[0]), 32'd1);
        fork
            see(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
            see(1, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 1'b0);
        join

        // randomized traffic checked by the per-instance model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            push_en   = (fcnt[0] < 4) && ($urandom_range(0, 2) != 0);
            push_data = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                push_en = 1'b0;
                #2;
                rst = 1'b0;
                @(posedge clk);
                #3;
                rst = 1'b1;
            end
        end
        push_en   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
